lanzones: RTL and testbench
===========================

Name: lanzones

Overview:
- lanzones is a minimal multi-cycle RV32I integer core.
- It fetches instructions and loads data through one read-only, word-addressed request/valid memory port.
- It executes a base-integer subset and has no data write port.
- It sits at the top of the CPU datapath, directly attached to a single-ported instruction/data memory model.

Parameters:
- RESET_PC, 32'h0000_0000: byte address of the first fetch.
- XLEN, 32: datapath width (fixed; not user-varied).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  one clock; reset is asynchronous and active-high.
- LEn  input  1  run enable. Core fetches and executes only while high.
- RRdy  output  1  read request. Held high while awaiting RVld.
- RAddr  output  32  word address of the request (byte address >> 2, upper 2 bits zero).
- RVld  input  1  read data valid. Single-cycle pulse from memory.
- RData  input  32  read data. Valid only while RVld=1.

Behaviour:
- Reset (async, rstn=1):
  - state=IDLE, PC=RESET_PC, IR=0.
  - x1..x31=0.
  - RRdy=0, RAddr=0.
- x0 reads 0 always; writes to it are discarded.
- Memory protocol:
  - Memory samples RRdy at a clock edge and returns RData with RVld=1 one cycle later.
  - RVld is never high on two consecutive cycles.
  - RRdy and RAddr are registered. RAddr is stable the whole time RRdy=1.
  - The core captures RData only on the cycle RVld=1.
- FSM, states IDLE, FETCH, EXEC, LOAD:
  - IDLE: RRdy=0. If LEn=1, go to FETCH with RRdy<=1, RAddr<=PC>>2.
  - FETCH: wait for RVld. On RVld, IR<=RData, RRdy<=0, go to EXEC.
  - EXEC (1 cycle), non-load instruction: write rd, update PC. Then if LEn=1 go to FETCH and issue the new request; else go to IDLE.
  - EXEC, LW: RAddr<=(rs1+sext(imm))>>2, RRdy<=1, go to LOAD.
  - LOAD: on RVld, rd<=RData, PC<=PC+4. Next state follows the same LEn rule as EXEC.
- Latency: 3 cycles per non-load instruction with the one-cycle memory; 5 cycles per LW.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target bit0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - OP-IMM: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - OP: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - LW.
- LB/LH/LBU/LHU are executed as LW (full word).
- Stores, FENCE, SYSTEM and all unknown opcodes act as NOPs (PC+4, no register write).
- Arithmetic wraps modulo 2^32. Shift amount = low 5 bits.
- Address bits [1:0] are ignored for all memory requests; no misalignment trap.
- If LEn drops mid-instruction, the current instruction completes; the core then parks in IDLE with PC pointing at the next instruction. Re-asserting LEn resumes from that PC.
- Reset mid-transaction aborts it immediately. RRdy=0 and the pending RVld is ignored (state is IDLE).
- An RVld arriving in IDLE or EXEC is ignored.

Decomposition:
- Package lanzones_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, OP_IMM, OP);
  - funct3 codes;
  - the state enum;
  - RESET_PC.
- One sub-module, lanzones_alu: combinational; operands a, b, funct3, funct7-bit30, op-type in; 32-bit result and branch-taken out.
- Register file and FSM stay in lanzones.

Test Plan:
- Reset with LEn=0 for 10 cycles -> RRdy=0, RAddr=0 throughout. Raise LEn -> next cycle RRdy=1, RAddr=0.
- mem[0]=0x00800093 (addi x1,x0,8), mem[1]=0x0000A103 (lw x2,0(x1)), mem[2]=0x0000006F (jal x0,0), mem[2] word loaded by LW -> x1=8; load request has RAddr=2; x2=0x0000006F.
- Same program -> fetch RAddr sequence is 0, 1, (load 2), 2, 2, 2..., with RRdy never high in an EXEC cycle.
- Program: addi x1,x0,-1; addi x1,x1,1; bne x1,x0,-4; jal x0,0 -> x1 reaches 0 and the branch falls through. Also addi x0,x0,5 -> x0 stays 0.
- Drop LEn while the core is in the LOAD state -> load completes and x2 is written; RRdy stays 0 afterwards and PC is held. Re-raise LEn -> fetch resumes at the next word.
- Assert rstn while RRdy=1 in FETCH -> RRdy=0 and RAddr=0 immediately (asynchronously). After release with LEn=1, fetch restarts at address 0.

Source files
------------

// File: rtl/lanzones_pkg.sv
// Shared constants and types for the lanzones RV32I core.
package lanzones_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // Major opcodes (instr[6:0]) the core acts on; everything else is a NOP.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 codes for OP / OP-IMM.
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 codes for BRANCH.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        LOAD  = 2'd3
    } state_t;

    // ALU_REG allows funct7[5] to select SUB; ALU_IMM ignores it except for SRAI.
    typedef enum logic [1:0] {
        ALU_IMM = 2'd0,
        ALU_REG = 2'd1,
        ALU_BR  = 2'd2
    } alu_op_t;

    // Byte address to word address; upper two bits come out zero.
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/lanzones_if.sv
// Read-only memory port between the core (master) and memory (slave).
//
// Handshake: the master raises RRdy with a stable RAddr and holds both until
// it sees RVld. Memory samples RRdy on a rising edge and answers one cycle
// later with a single-cycle RVld pulse carrying RData; RVld is never high on
// two consecutive cycles. RData is only meaningful while RVld=1.
interface lanzones_if;
    import lanzones_pkg::*;

    logic            RRdy;
    logic [XLEN-1:0] RAddr;
    logic            RVld;
    logic [XLEN-1:0] RData;

    modport master (output RRdy, output RAddr, input RVld, input RData);
    modport slave  (input RRdy, input RAddr, output RVld, output RData);
endinterface

// File: rtl/lanzones_alu.sv
// Combinational integer ALU and branch comparator.
module lanzones_alu
    import lanzones_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    input  logic            alt,
    input  alu_op_t         op,
    output logic [XLEN-1:0] result,
    output logic            taken
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // Arithmetic/logic result or branch decision, selected by op.
    always_comb begin
        result = '0;
        taken  = 1'b0;
        if (op == ALU_BR) begin
            case (funct3)
                F3_BEQ:  taken = (a == b);
                F3_BNE:  taken = (a != b);
                F3_BLT:  taken = ($signed(a) < $signed(b));
                F3_BGE:  taken = ($signed(a) >= $signed(b));
                F3_BLTU: taken = (a < b);
                F3_BGEU: taken = (a >= b);
                default: taken = 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_ADD:  result = (op == ALU_REG && alt) ? (a - b) : (a + b);
                F3_SLL:  result = a << shamt;
                F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                F3_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
                F3_XOR:  result = a ^ b;
                F3_SR:   result = alt ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
                F3_OR:   result = a | b;
                F3_AND:  result = a & b;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/lanzones.sv
// Minimal multi-cycle RV32I core: IDLE -> FETCH -> EXEC [-> LOAD] -> FETCH/IDLE.
module lanzones #(
    parameter logic [31:0] RESET_PC = lanzones_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  LEn,
    lanzones_if.master            bus,
    output lanzones_pkg::state_t  dbg_state,
    output logic [31:0]           dbg_pc
);
    import lanzones_pkg::*;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] ir, ir_n;
    logic            rrdy_n;
    logic [XLEN-1:0] raddr_n;
    logic [XLEN-1:0] regs [32];

    logic            wr_en;
    logic [XLEN-1:0] wr_data;

    // Instruction fields.
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1_idx, rs2_idx;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val, rs1_imm, pc_plus4;

    assign opcode  = ir[6:0];
    assign rd      = ir[11:7];
    assign funct3  = ir[14:12];
    assign rs1_idx = ir[19:15];
    assign rs2_idx = ir[24:20];
    assign imm_i   = {{20{ir[31]}}, ir[31:20]};
    assign imm_u   = {ir[31:12], 12'b0};
    assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign rs1_val  = (rs1_idx == 5'd0) ? '0 : regs[rs1_idx];
    assign rs2_val  = (rs2_idx == 5'd0) ? '0 : regs[rs2_idx];
    assign rs1_imm  = rs1_val + imm_i;
    assign pc_plus4 = pc + 32'd4;

    assign dbg_state = state;
    assign dbg_pc    = pc;

    // ALU operand/op selection.
    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_b, alu_res;
    logic            br_taken;

    assign alu_op = (opcode == OPC_BRANCH) ? ALU_BR :
                    (opcode == OPC_OP)     ? ALU_REG : ALU_IMM;
    assign alu_b  = (opcode == OPC_BRANCH || opcode == OPC_OP) ? rs2_val : imm_i;

    lanzones_alu u_alu (
        .a      (rs1_val),
        .b      (alu_b),
        .funct3 (funct3),
        .alt    (ir[30]),
        .op     (alu_op),
        .result (alu_res),
        .taken  (br_taken)
    );

    // Next PC and writeback value for a non-load instruction in EXEC.
    logic [XLEN-1:0] exec_pc, exec_wdata;
    logic            exec_wen;

    always_comb begin
        exec_pc    = pc_plus4;
        exec_wdata = '0;
        exec_wen   = 1'b0;
        case (opcode)
            OPC_LUI:    begin exec_wen = 1'b1; exec_wdata = imm_u; end
            OPC_AUIPC:  begin exec_wen = 1'b1; exec_wdata = pc + imm_u; end
            OPC_JAL:    begin exec_wen = 1'b1; exec_wdata = pc_plus4; exec_pc = pc + imm_j; end
            OPC_JALR:   begin exec_wen = 1'b1; exec_wdata = pc_plus4; exec_pc = rs1_imm & ~32'h1; end
            OPC_BRANCH: exec_pc = br_taken ? (pc + imm_b) : pc_plus4;
            OPC_OP_IMM: begin exec_wen = 1'b1; exec_wdata = alu_res; end
            OPC_OP:     begin exec_wen = 1'b1; exec_wdata = alu_res; end
            default:    exec_pc = pc_plus4;
        endcase
    end

    // FSM next-state, PC/IR update, memory request and register write.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        rrdy_n  = bus.RRdy;
        raddr_n = bus.RAddr;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state)
            IDLE: begin
                rrdy_n = 1'b0;
                if (LEn) begin
                    state_n = FETCH;
                    rrdy_n  = 1'b1;
                    raddr_n = word_addr(pc);
                end
            end
            FETCH: begin
                if (bus.RVld) begin
                    ir_n    = bus.RData;
                    rrdy_n  = 1'b0;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (opcode == OPC_LOAD) begin
                    raddr_n = word_addr(rs1_imm);
                    rrdy_n  = 1'b1;
                    state_n = LOAD;
                end else begin
                    wr_en   = exec_wen;
                    wr_data = exec_wdata;
                    pc_n    = exec_pc;
                    if (LEn) begin
                        state_n = FETCH;
                        rrdy_n  = 1'b1;
                        raddr_n = word_addr(exec_pc);
                    end else begin
                        state_n = IDLE;
                        rrdy_n  = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (bus.RVld) begin
                    wr_en   = 1'b1;
                    wr_data = bus.RData;
                    pc_n    = pc_plus4;
                    if (LEn) begin
                        state_n = FETCH;
                        rrdy_n  = 1'b1;
                        raddr_n = word_addr(pc_plus4);
                    end else begin
                        state_n = IDLE;
                        rrdy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                rrdy_n  = 1'b0;
            end
        endcase
    end

    // Control state, PC, IR and the registered memory request.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            bus.RRdy  <= 1'b0;
            bus.RAddr <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            bus.RRdy  <= rrdy_n;
            bus.RAddr <= raddr_n;
        end
    end

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_en && rd != 5'd0) begin
            regs[rd] <= wr_data;
        end
    end

endmodule

// File: tb/tb_lanzones.sv
// Directed testbench for the lanzones core with a one-cycle memory model.
module tb_lanzones;
    import lanzones_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        LEn = 1'b0;
    state_t      dbg_state;
    logic [31:0] dbg_pc;

    int errors = 0;
    int checks = 0;

    lanzones_if bus ();

    lanzones dut (
        .clk       (clk),
        .rstn      (rstn),
        .LEn       (LEn),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_pc    (dbg_pc)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [64];

    always @(posedge clk) begin
        bus.RVld <= bus.RRdy && !bus.RVld;
        if (bus.RRdy && !bus.RVld) bus.RData <= mem[bus.RAddr[5:0]];
    end

    // ---------------- request monitor ----------------
    logic [31:0] req_q[$];
    logic [31:0] load_q[$];
    int          exec_rrdy_cnt = 0;

    always @(posedge clk) begin
        if (!rstn && bus.RRdy && !bus.RVld) begin
            req_q.push_back(bus.RAddr);
            if (dbg_state == LOAD) load_q.push_back(bus.RAddr);
        end
    end

    always @(negedge clk) begin
        if (!rstn && dbg_state == EXEC && bus.RRdy) exec_rrdy_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        LEn  = 1'b0;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic load_prog_a();
        clear_mem();
        mem[0] = 32'h0080_0093;  // addi x1,x0,8
        mem[1] = 32'h0000_A103;  // lw   x2,0(x1)
        mem[2] = 32'h0000_006F;  // jal  x0,0
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic all_zero;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.RRdy !== 1'b0 || bus.RAddr !== 32'h0)
                $display("FAIL reset_idle cyc%0d: RRdy=%0b RAddr=%0h, want 0/0", c, bus.RRdy, bus.RAddr);
            if (bus.RRdy !== 1'b0 || bus.RAddr !== 32'h0) errors++;
        end
        checks++;
        if (dbg_state !== IDLE || dbg_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: state=%0d pc=%0h, want 0/0", dbg_state, dbg_pc);
        end
        all_zero = 1'b1;
        for (int r = 0; r < 32; r++) if (dut.regs[r] !== 32'h0) all_zero = 1'b0;
        checks++;
        if (!all_zero) begin
            errors++;
            $display("FAIL reset_regs: some register nonzero after reset, want all 0");
        end
        LEn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.RRdy !== 1'b1 || bus.RAddr !== 32'h0) begin
            errors++;
            $display("FAIL first_fetch: RRdy=%0b RAddr=%0h, want 1/0", bus.RRdy, bus.RAddr);
        end
    endtask

    task automatic test_load_program();
        int lbase;
        load_prog_a();
        do_reset();
        lbase = load_q.size();
        LEn = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (dut.regs[1] !== 32'd8) begin
            errors++;
            $display("FAIL lw_x1: x1=%0h, want 8", dut.regs[1]);
        end
        checks++;
        if (dut.regs[2] !== 32'h0000_006F) begin
            errors++;
            $display("FAIL lw_x2: x2=%0h, want 6f", dut.regs[2]);
        end
        checks++;
        if (load_q.size() <= lbase) begin
            errors++;
            $display("FAIL lw_addr: no load request seen, want RAddr=2");
        end else if (load_q[lbase] !== 32'd2) begin
            errors++;
            $display("FAIL lw_addr: RAddr=%0h, want 2", load_q[lbase]);
        end
        checks++;
        if (dbg_pc !== 32'h8) begin
            errors++;
            $display("FAIL lw_pc: pc=%0h, want 8", dbg_pc);
        end
    endtask

    task automatic test_fetch_sequence();
        logic [31:0] exp_q[$];
        int base, ebase;
        load_prog_a();
        do_reset();
        base  = req_q.size();
        ebase = exec_rrdy_cnt;
        exp_q = {32'd0, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2};
        LEn = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (req_q.size() - base < exp_q.size()) begin
            errors++;
            $display("FAIL req_count: %0d requests, want at least %0d", req_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (req_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL req_seq[%0d]: RAddr=%0h, want %0h", i, req_q[base + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (exec_rrdy_cnt != ebase) begin
            errors++;
            $display("FAIL rrdy_in_exec: %0d cycles with RRdy=1 in EXEC, want 0", exec_rrdy_cnt - ebase);
        end
    endtask

    task automatic test_loop_x0();
        clear_mem();
        mem[0] = 32'hFFF0_0093;  // addi x1,x0,-1
        mem[1] = 32'h0010_8093;  // addi x1,x1,1
        mem[2] = 32'hFE00_9EE3;  // bne  x1,x0,-4
        mem[3] = 32'h0050_0013;  // addi x0,x0,5
        mem[4] = 32'h0000_006F;  // jal  x0,0
        do_reset();
        LEn = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (dut.regs[1] !== 32'h0) begin
            errors++;
            $display("FAIL loop_x1: x1=%0h, want 0", dut.regs[1]);
        end
        checks++;
        if (dut.regs[0] !== 32'h0) begin
            errors++;
            $display("FAIL x0_zero: x0=%0h, want 0", dut.regs[0]);
        end
        checks++;
        if (dbg_pc !== 32'h10) begin
            errors++;
            $display("FAIL loop_pc: pc=%0h, want 10", dbg_pc);
        end
    endtask

    task automatic test_alu_program();
        int          idx [13];
        logic [31:0] val [13];
        clear_mem();
        mem[0]  = 32'hFF80_0093;  // addi x1,x0,-8
        mem[1]  = 32'h0030_0113;  // addi x2,x0,3
        mem[2]  = 32'h4020_81B3;  // sub  x3,x1,x2
        mem[3]  = 32'h4020_D233;  // sra  x4,x1,x2
        mem[4]  = 32'h0020_D2B3;  // srl  x5,x1,x2
        mem[5]  = 32'h0011_3333;  // sltu x6,x2,x1
        mem[6]  = 32'h0011_23B3;  // slt  x7,x2,x1
        mem[7]  = 32'h1234_5437;  // lui  x8,0x12345
        mem[8]  = 32'h0000_1497;  // auipc x9,1
        mem[9]  = 32'h0080_056F;  // jal  x10,+8
        mem[10] = 32'h0010_0593;  // addi x11,x0,1 (skipped)
        mem[11] = 32'h4010_D613;  // srai x12,x1,1
        mem[12] = 32'h0020_C463;  // blt  x1,x2,+8
        mem[13] = 32'h0020_0593;  // addi x11,x0,2 (skipped)
        mem[14] = 32'h0410_06E7;  // jalr x13,0x41(x0)
        mem[15] = 32'h0030_0593;  // addi x11,x0,3 (skipped)
        mem[16] = 32'h0000_006F;  // jal  x0,0
        idx = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
        val = '{32'hFFFF_FFF8, 32'h0000_0003, 32'hFFFF_FFF5, 32'hFFFF_FFFF,
                32'h1FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h1234_5000,
                32'h0000_1020, 32'h0000_0028, 32'h0000_0000, 32'hFFFF_FFFC,
                32'h0000_003C};
        do_reset();
        LEn = 1'b1;
        repeat (120) @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (dut.regs[idx[i]] !== val[i]) begin
                errors++;
                $display("FAIL alu_x%0d: got %0h, want %0h", idx[i], dut.regs[idx[i]], val[i]);
            end
        end
        checks++;
        if (dbg_pc !== 32'h40) begin
            errors++;
            $display("FAIL alu_pc: pc=%0h, want 40", dbg_pc);
        end
    endtask

    task automatic test_len_drop_in_load();
        int  n;
        logic held;
        load_prog_a();
        do_reset();
        LEn = 1'b1;
        n = 0;
        while (dbg_state != LOAD && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dbg_state != LOAD) begin
            errors++;
            $display("FAIL reach_load: state=%0d after %0d cycles, want LOAD", dbg_state, n);
        end
        LEn = 1'b0;
        n = 0;
        while (dbg_state != IDLE && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dbg_state != IDLE) begin
            errors++;
            $display("FAIL park_idle: state=%0d, want IDLE", dbg_state);
        end
        checks++;
        if (dut.regs[2] !== 32'h0000_006F) begin
            errors++;
            $display("FAIL drop_x2: x2=%0h, want 6f", dut.regs[2]);
        end
        held = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.RRdy !== 1'b0 || dbg_pc !== 32'h8) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL park_hold: RRdy=%0b pc=%0h, want 0/8 throughout", bus.RRdy, dbg_pc);
        end
        LEn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.RRdy !== 1'b1 || bus.RAddr !== 32'd2) begin
            errors++;
            $display("FAIL resume: RRdy=%0b RAddr=%0h, want 1/2", bus.RRdy, bus.RAddr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n, base;
        load_prog_a();
        do_reset();
        LEn = 1'b1;
        n = 0;
        while (!(bus.RRdy === 1'b1 && bus.RAddr === 32'd1 && dbg_state == FETCH) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(bus.RRdy === 1'b1 && bus.RAddr === 32'd1)) begin
            errors++;
            $display("FAIL reach_fetch1: RRdy=%0b RAddr=%0h, want 1/1", bus.RRdy, bus.RAddr);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (bus.RRdy !== 1'b0 || bus.RAddr !== 32'h0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset: RRdy=%0b RAddr=%0h state=%0d, want 0/0/IDLE",
                     bus.RRdy, bus.RAddr, dbg_state);
        end
        repeat (2) @(negedge clk);
        base = req_q.size();
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.RRdy !== 1'b1 || bus.RAddr !== 32'h0) begin
            errors++;
            $display("FAIL restart_fetch: RRdy=%0b RAddr=%0h, want 1/0", bus.RRdy, bus.RAddr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (req_q.size() <= base || req_q[base] !== 32'h0) begin
            errors++;
            $display("FAIL restart_req: first request after reset wrong or missing, want RAddr=0");
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        clear_mem();
        test_reset();
        test_load_program();
        test_fetch_sequence();
        test_loop_x0();
        test_alu_program();
        test_len_drop_in_load();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
